// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional divide-by-zero guard with err output: define ALU_DIVZERO_CHK_EN.
module alu_arbiter #(
    parameter int WAIT_CYC = 1,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [2:0]  sel0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    output logic        done0,
    input  logic        req1,
    input  logic [2:0]  sel1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done1,
    output logic [31:0] res,
    output logic        z,
`ifdef ALU_DIVZERO_CHK_EN
    output logic        err,
`endif
    output logic        busy,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_res,
    input  logic        alu_z
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       op1_q, op1_d;
    logic [31:0]       op2_q, op2_d;
    logic [2:0]        sel_q, sel_d;
    logic [31:0]       res_q, res_d;
    logic              z_q, z_d;
    logic              err_q, err_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              busy_q, busy_d;
    logic              grant1_s;

    // Next-state, grant selection and result capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        sel_d        = sel_q;
        res_d        = res_q;
        z_d          = z_q;
        err_d        = err_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        // Port 1 wins only if port 0 is idle or port 0 had the last grant
        grant1_s     = req1 && (!req0 || !last_grant_q);

        case (state_q)
            ST_IDLE: begin
                op1_d = 32'd0;
                op2_d = 32'd0;
                sel_d = 3'b000;
                if (req0 || req1) begin
                    owner_d      = grant1_s;
                    last_grant_d = grant1_s;
                    op1_d        = grant1_s ? a1 : a0;
                    op2_d        = grant1_s ? b1 : b0;
                    sel_d        = grant1_s ? sel1 : sel0;
                    cnt_d        = {CNT_W{1'b0}};
                    state_d      = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_q == LAST_CNT) begin
                    res_d = alu_res;
                    z_d   = alu_z;
                    err_d = 1'b0;
                    if (sel_q == 3'b111) begin
                        res_d = 32'd0;
                        z_d   = 1'b1;
                    end
`ifdef ALU_DIVZERO_CHK_EN
                    else if ((sel_q == 3'b011) && (op2_q == 32'd0)) begin
                        res_d = 32'hFFFF_FFFF;
                        z_d   = 1'b0;
                        err_d = 1'b1;
                    end
`endif
                    else begin
                        res_d = alu_res;
                    end
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Requests are ignored here so the owner can drop req
                op1_d   = 32'd0;
                op2_d   = 32'd0;
                sel_d   = 3'b000;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op1_q        <= 32'd0;
            op2_q        <= 32'd0;
            sel_q        <= 3'b000;
            res_q        <= 32'd0;
            z_q          <= 1'b0;
            err_q        <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            sel_q        <= sel_d;
            res_q        <= res_d;
            z_q          <= z_d;
            err_q        <= err_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            busy_q       <= busy_d;
        end
    end

    assign done0   = done0_q;
    assign done1   = done1_q;
    assign res     = res_q;
    assign z       = z_q;
    assign busy    = busy_q;
    assign alu_op1 = op1_q;
    assign alu_op2 = op2_q;
    assign alu_sel = sel_q;
`ifdef ALU_DIVZERO_CHK_EN
    assign err     = err_q;
`else
    logic unused_err_s;
    assign unused_err_s = err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one instance with WAIT_CYC=1, one with WAIT_CYC=3.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        req0, req1, done0, done1, z, busy, alu_z;
    logic [2:0]  sel0, sel1, alu_sel;
    logic [31:0] a0, b0, a1, b1, res, alu_op1, alu_op2, alu_res;
    logic        c_req0, c_req1, c_done0, c_done1, c_z, c_busy, c_alu_z;
    logic [2:0]  c_sel0, c_sel1, c_alu_sel;
    logic [31:0] c_a0, c_b0, c_a1, c_b1, c_res, c_alu_op1, c_alu_op2, c_alu_res;
`ifdef ALU_DIVZERO_CHK_EN
    logic err, c_err;
`endif

    int checks = 0;
    int failures = 0;

    // Reference ALU: {zero, result}; no-op select returns a junk value
    function automatic logic [32:0] alu_fn(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (s)
            3'b000:  r = x + y;
            3'b001:  r = x - y;
            3'b010:  r = x * y;
            3'b011:  r = (y == 32'd0) ? 32'd0 : x / y;
            3'b100:  r = x | y;
            3'b101:  r = x & y;
            3'b110:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = 32'hDEAD_BEEF;
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {alu_z, alu_res}     = alu_fn(alu_sel, alu_op1, alu_op2);
    assign {c_alu_z, c_alu_res} = alu_fn(c_alu_sel, c_alu_op1, c_alu_op2);

    alu_arbiter #(.WAIT_CYC(1), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .sel0(sel0), .a0(a0), .b0(b0), .done0(done0),
        .req1(req1), .sel1(sel1), .a1(a1), .b1(b1), .done1(done1),
        .res(res), .z(z),
`ifdef ALU_DIVZERO_CHK_EN
        .err(err),
`endif
        .busy(busy), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_res(alu_res), .alu_z(alu_z)
    );

    alu_arbiter #(.WAIT_CYC(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0(c_req0), .sel0(c_sel0), .a0(c_a0), .b0(c_b0), .done0(c_done0),
        .req1(c_req1), .sel1(c_sel1), .a1(c_a1), .b1(c_b1), .done1(c_done1),
        .res(c_res), .z(c_z),
`ifdef ALU_DIVZERO_CHK_EN
        .err(c_err),
`endif
        .busy(c_busy), .alu_op1(c_alu_op1), .alu_op2(c_alu_op2), .alu_sel(c_alu_sel),
        .alu_res(c_alu_res), .alu_z(c_alu_z)
    );

    typedef struct {
        logic        port;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  sel;
        logic [31:0] res;
        logic        z;
        logic        err;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] m;
        m = alu_fn(s, a, b);
        e.port = port; e.op1 = a; e.op2 = b; e.sel = s;
        e.res = m[31:0]; e.z = m[32]; e.err = 1'b0;
        if (s == 3'b111) begin
            e.res = 32'd0; e.z = 1'b1;
        end
`ifdef ALU_DIVZERO_CHK_EN
        if (s == 3'b011 && b == 32'd0) begin
            e.res = 32'hFFFF_FFFF; e.z = 1'b0; e.err = 1'b1;
        end
`endif
        sb.push_back(e);
    endtask

    // Waits for the next done of the chosen instance and checks it against the scoreboard head
    task automatic wait_done(input bit use_c, input int wc, input int gap, input string tag);
        int n, nbusy;
        bit seen, both, ops_bad;
        logic d0, d1, bsy, zz, ee;
        logic [31:0] r, o1, o2;
        logic [2:0] os;
        exp_t e;
        n = 0; nbusy = 0; seen = 0; both = 0; ops_bad = 0;
        d1 = 1'b0; r = 32'd0; zz = 1'b0; ee = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            n++;
            d0  = use_c ? c_done0 : done0;
            d1  = use_c ? c_done1 : done1;
            bsy = use_c ? c_busy : busy;
            o1  = use_c ? c_alu_op1 : alu_op1;
            o2  = use_c ? c_alu_op2 : alu_op2;
            os  = use_c ? c_alu_sel : alu_sel;
            r   = use_c ? c_res : res;
            zz  = use_c ? c_z : z;
`ifdef ALU_DIVZERO_CHK_EN
            ee  = use_c ? c_err : err;
`endif
            if (d0 && d1) both = 1;
            if (bsy) begin
                nbusy++;
                if (sb.size() > 0 && (o1 !== sb[0].op1 || o2 !== sb[0].op2 || os !== sb[0].sel)) ops_bad = 1;
            end
            if (d0 || d1) seen = 1;
        end
        check({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_port"}, {31'd0, d1}, {31'd0, e.port});
            check({tag, "_res"}, r, e.res);
            check({tag, "_z"}, {31'd0, zz}, {31'd0, e.z});
            check({tag, "_lat"}, n, wc + 1 + gap);
            check({tag, "_busy_cyc"}, nbusy, wc + 1);
            check({tag, "_ops_held"}, {31'd0, ops_bad}, 32'd0);
            check({tag, "_both_done"}, {31'd0, both}, 32'd0);
`ifdef ALU_DIVZERO_CHK_EN
            check({tag, "_err"}, {31'd0, ee}, {31'd0, e.err});
`endif
        end
    endtask

    task automatic idle_check(input bit use_c, input string tag);
        @(negedge clk);
        check({tag, "_done0"}, {31'd0, use_c ? c_done0 : done0}, 32'd0);
        check({tag, "_done1"}, {31'd0, use_c ? c_done1 : done1}, 32'd0);
        check({tag, "_busy"}, {31'd0, use_c ? c_busy : busy}, 32'd0);
        check({tag, "_op1"}, use_c ? c_alu_op1 : alu_op1, 32'd0);
        check({tag, "_sel"}, {29'd0, use_c ? c_alu_sel : alu_sel}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; sel0 = 3'd0; sel1 = 3'd0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        c_req0 = 1'b0; c_req1 = 1'b0; c_sel0 = 3'd0; c_sel1 = 3'd0;
        c_a0 = 32'd0; c_b0 = 32'd0; c_a1 = 32'd0; c_b1 = 32'd0;

        @(negedge clk);
        check("rst_res", res, 32'd0);
        check("rst_z", {31'd0, z}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {30'd0, done1, done0}, 32'd0);
        check("rst_op1", alu_op1, 32'd0);
        check("rst_op2", alu_op2, 32'd0);
        check("rst_sel", {29'd0, alu_sel}, 32'd0);
        check("rst3_busy", {31'd0, c_busy}, 32'd0);
        rst_n = 1'b1;

        // Single ADD on port 0
        req0 = 1'b1; sel0 = 3'b000; a0 = 32'd5; b0 = 32'd7;
        push_exp(1'b0, 3'b000, 32'd5, 32'd7);
        wait_done(1'b0, 1, 0, "add");
        req0 = 1'b0;
        idle_check(1'b0, "add_idle");

        // No-op select: fixed result, ALU output ignored
        req0 = 1'b1; sel0 = 3'b111; a0 = 32'd3; b0 = 32'd4;
        push_exp(1'b0, 3'b111, 32'd3, 32'd4);
        wait_done(1'b0, 1, 0, "nop");
        req0 = 1'b0;
        idle_check(1'b0, "nop_idle");

        // SUB to zero on port 1
        req1 = 1'b1; sel1 = 3'b001; a1 = 32'h1234; b1 = 32'h1234;
        push_exp(1'b1, 3'b001, 32'h1234, 32'h1234);
        wait_done(1'b0, 1, 0, "sub");
        req1 = 1'b0;
        idle_check(1'b0, "sub_idle");

        // Both held from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        req0 = 1'b1; sel0 = 3'b100; a0 = 32'hF0; b0 = 32'h0F;
        req1 = 1'b1; sel1 = 3'b101; a1 = 32'hF0; b1 = 32'h0F;
        #1;
        check("rr_rst_busy", {31'd0, busy}, 32'd0);
        check("rr_rst_done", {30'd0, done1, done0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(1'b0, 3'b100, 32'hF0, 32'h0F);
        push_exp(1'b1, 3'b101, 32'hF0, 32'h0F);
        push_exp(1'b0, 3'b100, 32'hF0, 32'h0F);
        push_exp(1'b1, 3'b101, 32'hF0, 32'h0F);
        wait_done(1'b0, 1, 0, "rr0");
        wait_done(1'b0, 1, 1, "rr1");
        wait_done(1'b0, 1, 1, "rr2");
        wait_done(1'b0, 1, 1, "rr3");
        req0 = 1'b0; req1 = 1'b0;
        idle_check(1'b0, "rr_idle");

        // Three settle cycles: MUL on the WAIT_CYC=3 instance
        c_req0 = 1'b1; c_sel0 = 3'b010; c_a0 = 32'd6; c_b0 = 32'd7;
        push_exp(1'b0, 3'b010, 32'd6, 32'd7);
        wait_done(1'b1, 3, 0, "mul3");
        c_req0 = 1'b0;
        idle_check(1'b1, "mul3_idle");

        // Reset during EXEC, then completion with req still held
        c_req0 = 1'b1; c_sel0 = 3'b001; c_a0 = 32'd100; c_b0 = 32'd1;
        @(negedge clk);
        check("mid_busy_pre", {31'd0, c_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, c_busy}, 32'd0);
        check("mid_rst_res", c_res, 32'd0);
        check("mid_rst_op1", c_alu_op1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_done", {30'd0, c_done1, c_done0}, 32'd0);
        end
        rst_n = 1'b1;
        push_exp(1'b0, 3'b001, 32'd100, 32'd1);
        wait_done(1'b1, 3, 0, "mid_after");
        c_req0 = 1'b0;
        idle_check(1'b1, "mid_idle");

        // Divide by zero, then a normal divide
        req0 = 1'b1; sel0 = 3'b011; a0 = 32'd10; b0 = 32'd0;
        push_exp(1'b0, 3'b011, 32'd10, 32'd0);
        wait_done(1'b0, 1, 0, "div0");
        req0 = 1'b0;
        idle_check(1'b0, "div0_idle");
        req0 = 1'b1; sel0 = 3'b011; a0 = 32'd10; b0 = 32'd2;
        push_exp(1'b0, 3'b011, 32'd10, 32'd2);
        wait_done(1'b0, 1, 0, "div");
        req0 = 1'b0;
        idle_check(1'b0, "div_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
